bus_err_collector: RTL
======================

Name: bus_err_collector

Overview:
Aggregates the error FIFOs of NumUnits bus error units into one software-facing error stream. Round-robin arbiter picks a unit with a pending error, captures its head entry (code, addr, meta, source index), pops that unit's FIFO, and holds the entry on a valid/ready output until consumed. Masked units are drained automatically and counted. Overflow flags are kept sticky, and a single interrupt is raised. Sits between the per-master bus error units and the SoC register file / interrupt controller.

Parameters:
NumUnits, 4, number of attached bus error units (>=1)
AddrWidth, 48, error address width
MetaDataWidth, 1, error metadata width
ErrBits, 3, error code width
CntWidth, 16, width of the saturating drop counter
SrcWidth, cf_math_pkg::idx_width(NumUnits), width of the source index (derived, do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
unit_err_valid_i  in  NumUnits  per-unit error FIFO non-empty (err_irq_o of the unit)
unit_err_code_i  in  NumUnits*ErrBits  per-unit head error code
unit_err_addr_i  in  NumUnits*AddrWidth  per-unit head address
unit_err_meta_i  in  NumUnits*MetaDataWidth  per-unit head metadata
unit_overflow_i  in  NumUnits  per-unit overflow indication
unit_pop_o  out  NumUnits  per-unit FIFO pop (err_fifo_pop_i of the unit)
unit_mask_i  in  NumUnits  1 = unit masked: drained, not reported
err_valid_o  out  1  captured error available
err_ready_i  in  1  consumer accepts captured error
err_code_o  out  ErrBits  captured code
err_addr_o  out  AddrWidth  captured address
err_meta_o  out  MetaDataWidth  captured metadata
err_src_o  out  SrcWidth  index of the originating unit
overflow_o  out  NumUnits  sticky per-unit overflow
overflow_clr_i  in  NumUnits  per-bit clear of overflow_o
drop_cnt_o  out  CntWidth  count of drained (masked) errors
drop_cnt_clr_i  in  1  clear drop counter
irq_o  out  1  interrupt

Behaviour:
- Reset: FSM=IDLE, rr pointer=0, err_valid_o=0, err_code/addr/meta/src_o=0, overflow_o=0, drop_cnt_o=0, unit_pop_o=0, irq_o=0.
- Candidates: cand = unit_err_valid_i & ~unit_mask_i.
- IDLE: if |cand, select the first candidate at or after the rr pointer (wrapping modulo NumUnits). In the same cycle assert unit_pop_o[sel]=1 and capture that unit's code/addr/meta and sel into the output registers. Next state is HOLD, with err_valid_o=1 from the next cycle. Latency from unit valid to err_valid_o is 1 cycle.
- HOLD: the output registers are stable and no arbitration pop is issued. When err_valid_o & err_ready_i, go to IDLE, clear err_valid_o next cycle, and set rr pointer = (sel+1) mod NumUnits. Maximum throughput is one error per 2 cycles.
- Masking a unit while its captured entry is in HOLD does not affect the entry. The pop has already happened, so no second pop is issued.
- Drain: in every state, unit_pop_o[i] |= unit_mask_i[i] & unit_err_valid_i[i]. A masked unit is never selected, so no unit receives two pops in one cycle.
- drop_cnt: each cycle add popcount(unit_mask_i & unit_err_valid_i), saturating at all-ones with no wrap. drop_cnt_clr_i takes precedence over the increment in the same cycle; the counter loads 0.
- overflow_o[i]: set when unit_overflow_i[i]=1; cleared by overflow_clr_i[i]. Set wins over clear in the same cycle.
- irq_o is registered and equals err_valid_o_next | (|overflow_o_next). It is asserted the same cycle err_valid_o rises.
- NumUnits=1: the pointer is constant 0 and err_src_o=0.
- All state resets asynchronously. A reset during HOLD discards the captured entry, because the unit has already popped it.

Test Plan:
- Single error: unit 2 valid with code=3, addr=0x1000 -> unit_pop_o=4'b0100 for exactly 1 cycle. Next cycle err_valid_o=1, src=2, addr=0x1000, irq_o=1. With ready=1, err_valid_o drops the cycle after.
- Fairness: units 0 and 3 continuously valid, ready always 1 -> sources alternate 0,3,0,3 and one pop every 2 cycles.
- Backpressure: ready=0 for 10 cycles while unit 1 stays valid -> outputs stable, no further pops, pop issued only once per accept.
- Masked drain: mask=4'b0010, unit 1 valid for 5 cycles -> unit_pop_o[1] high for 5 cycles, drop_cnt_o=5, err_valid_o stays 0. Preload cnt=0xFFFE, drain 3 -> cnt=0xFFFF.
- Overflow: unit_overflow_i[0] pulses -> overflow_o=1 and irq_o=1. Clear and set in the same cycle -> stays 1; clear alone -> 0, and irq_o drops if err_valid_o=0.
- Reset mid-HOLD: assert rst_ni=0 while err_valid_o=1 -> all outputs 0 asynchronously, and after release the FSM is in IDLE with pointer 0.

Source files
------------

// File: rtl/bus_err_collector.sv
// Merges per-unit bus error FIFOs into one valid/ready error stream: round-robin pick, 1-cycle capture latency,
// held stable under backpressure (no further arbitration pops until accepted); masked units are drained and counted.
module bus_err_collector #(
  parameter int NumUnits      = 4,
  parameter int AddrWidth     = 48,
  parameter int MetaDataWidth = 1,
  parameter int ErrBits       = 3,
  parameter int CntWidth      = 16,
  localparam int SrcWidth     = (NumUnits > 1) ? $clog2(NumUnits) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumUnits-1:0]               unit_err_valid_i,
  input  logic [NumUnits*ErrBits-1:0]       unit_err_code_i,
  input  logic [NumUnits*AddrWidth-1:0]     unit_err_addr_i,
  input  logic [NumUnits*MetaDataWidth-1:0] unit_err_meta_i,
  input  logic [NumUnits-1:0]               unit_overflow_i,
  output logic [NumUnits-1:0]               unit_pop_o,
  input  logic [NumUnits-1:0]               unit_mask_i,
  output logic                              err_valid_o,
  input  logic                              err_ready_i,
  output logic [ErrBits-1:0]                err_code_o,
  output logic [AddrWidth-1:0]              err_addr_o,
  output logic [MetaDataWidth-1:0]          err_meta_o,
  output logic [SrcWidth-1:0]               err_src_o,
  output logic [NumUnits-1:0]               overflow_o,
  input  logic [NumUnits-1:0]               overflow_clr_i,
  output logic [CntWidth-1:0]               drop_cnt_o,
  input  logic                              drop_cnt_clr_i,
  output logic                              irq_o
);

  localparam int SumW = CntWidth + SrcWidth + 1;

  typedef enum logic {IDLE, HOLD} state_e;

  typedef struct packed {
    logic [ErrBits-1:0]       code;
    logic [AddrWidth-1:0]     addr;
    logic [MetaDataWidth-1:0] meta;
    logic [SrcWidth-1:0]      src;
  } entry_t;

  state_e                state_q, state_d;
  entry_t                entry_q, entry_d;
  logic [SrcWidth-1:0]   rr_q, rr_d;
  logic [NumUnits-1:0]   cand, drain, grant;
  logic [NumUnits-1:0]   ovf_q, ovf_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  irq_q, irq_d;
  logic                  found;
  logic [SrcWidth-1:0]   sel;
  logic [2*NumUnits-1:0] rot;
  logic [SrcWidth:0]     inc;
  logic [SumW-1:0]       sum;

  assign cand  = unit_err_valid_i & ~unit_mask_i;
  assign drain = unit_err_valid_i & unit_mask_i;

  // Rotate candidates so bit 0 is the rr pointer, then take the first set bit.
  always_comb begin
    int pos;
    found = 1'b0;
    sel   = '0;
    pos   = 0;
    rot   = {cand, cand} >> rr_q;
    for (int k = 0; k < NumUnits; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos   = int'(rr_q) + k;
        if (pos >= NumUnits) pos = pos - NumUnits;
        sel   = SrcWidth'(pos);
      end
    end
  end

  always_comb begin
    int nxt;
    state_d = state_q;
    entry_d = entry_q;
    rr_d    = rr_q;
    grant   = '0;
    nxt     = 0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant[sel]   = 1'b1;
          state_d      = HOLD;
          entry_d.code = unit_err_code_i[int'(sel)*ErrBits +: ErrBits];
          entry_d.addr = unit_err_addr_i[int'(sel)*AddrWidth +: AddrWidth];
          entry_d.meta = unit_err_meta_i[int'(sel)*MetaDataWidth +: MetaDataWidth];
          entry_d.src  = sel;
        end
      end
      HOLD: begin
        if (err_ready_i) begin
          state_d = IDLE;
          nxt     = int'(entry_q.src) + 1;
          if (nxt >= NumUnits) nxt = 0;
          rr_d    = SrcWidth'(nxt);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < NumUnits; i++) begin
      inc = inc + (SrcWidth+1)'(drain[i]);
    end
    sum = SumW'(cnt_q) + SumW'(inc);
    if (drop_cnt_clr_i) begin
      cnt_d = '0;
    end else if (|sum[SumW-1:CntWidth]) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[CntWidth-1:0];
    end
    ovf_d = (ovf_q & ~overflow_clr_i) | unit_overflow_i;
    irq_d = (state_d == HOLD) | (|ovf_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      entry_q <= '0;
      rr_q    <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  // Pops are blocked in reset: a popped entry could not be captured and would be lost.
  assign unit_pop_o  = rst_ni ? (drain | grant) : '0;
  assign err_valid_o = (state_q == HOLD);
  assign err_code_o  = entry_q.code;
  assign err_addr_o  = entry_q.addr;
  assign err_meta_o  = entry_q.meta;
  assign err_src_o   = entry_q.src;
  assign overflow_o  = ovf_q;
  assign drop_cnt_o  = cnt_q;
  assign irq_o       = irq_q;

endmodule
